// File: rtl/simple_spi_slave.sv
// -----------------------------------------------------------------------------
// simple_spi_slave
//
// SPI target peripheral. It receives SCK/SS_n/MOSI from an external master,
// resamples them into the clk_i domain and shifts one byte in and out per eight
// SCK cycles, in any of the four SPI modes (CPOL/CPHA). Software reaches it
// through an 8-bit Wishbone classic slave port that holds control, status and
// data registers, and it can raise an interrupt.
//
// Parameters
//   SYNC_STAGES  synchronizer depth for sck_i, ss_n_i and mosi_i (>= 2)
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   cyc_i/stb_i  Wishbone cycle / strobe
//   we_i         Wishbone write enable
//   adr_i[1:0]   register select: 0 CTRL, 1 STAT, 2 DATA, 3 reserved
//   dat_i[7:0]   write data
//   dat_o[7:0]   registered read data, valid while ack_o is high
//   ack_o        Wishbone acknowledge, one cycle after the access
//   inta_o       registered interrupt request
//   sck_i        SPI clock from the master (asynchronous)
//   ss_n_i       slave select, active-low (asynchronous)
//   mosi_i       master-out data (asynchronous)
//   miso_o       slave-out data, MSB first
//   miso_oe_o    MISO driver enable
// -----------------------------------------------------------------------------
module simple_spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cyc_i,
   input  logic       stb_i,
   input  logic       we_i,
   input  logic [1:0] adr_i,
   input  logic [7:0] dat_i,
   output logic [7:0] dat_o,
   output logic       ack_o,
   output logic       inta_o,
   input  logic       sck_i,
   input  logic       ss_n_i,
   input  logic       mosi_i,
   output logic       miso_o,
   output logic       miso_oe_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Pin synchronizers. Each stage holds {mosi, ss_n, sck}.
   // The chain resets to all-zero so that an SS_n held low through reset
   // never looks like a fresh falling edge: a frame already in progress
   // when reset releases is ignored until SS_n goes high and low again.
   // ---------------------------------------------------------------------
   logic [2:0] sync_reg [SYNC_STAGES];
   logic       sck_s;
   logic       ss_s;
   logic       mosi_s;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= 3'b000;
         end
      end else begin
         sync_reg[0] <= {mosi_i, ss_n_i, sck_i};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
      end
   end

   assign sck_s  = sync_reg[SYNC_STAGES-1][0];
   assign ss_s   = sync_reg[SYNC_STAGES-1][1];
   assign mosi_s = sync_reg[SYNC_STAGES-1][2];

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t     state_reg,     state_next;
   logic       sck_d_reg,     sck_d_next;
   logic       ss_d_reg,      ss_d_next;
   logic       ie_reg,        ie_next;
   logic       spe_reg,       spe_next;
   logic       cpol_reg,      cpol_next;
   logic       cpha_reg,      cpha_next;
   logic       rxf_reg,       rxf_next;
   logic       ovr_reg,       ovr_next;
   logic       txe_reg,       txe_next;
   logic       und_reg,       und_next;
   logic       wcol_reg,      wcol_next;
   logic [7:0] rx_hold_reg,   rx_hold_next;
   logic [7:0] tx_hold_reg,   tx_hold_next;
   logic [7:0] rx_sr_reg,     rx_sr_next;
   logic [7:0] tx_sr_reg,     tx_sr_next;
   logic [2:0] bcnt_reg,      bcnt_next;
   logic       byte_done_reg, byte_done_next;
   logic [7:0] dat_reg,       dat_next;
   logic       ack_reg,       ack_next;
   logic       inta_reg,      inta_next;

   // ---------------------------------------------------------------------
   // Edge events on the synchronized pins
   // ---------------------------------------------------------------------
   logic sck_rise, sck_fall, lead_evt, trail_evt, sample_evt, shift_evt;
   logic ss_fall, ss_rise;

   assign sck_rise   =  sck_s & ~sck_d_reg;
   assign sck_fall   = ~sck_s &  sck_d_reg;
   assign lead_evt   = cpol_reg ? sck_fall : sck_rise;
   assign trail_evt  = cpol_reg ? sck_rise : sck_fall;
   assign sample_evt = cpha_reg ? trail_evt : lead_evt;
   assign shift_evt  = cpha_reg ? lead_evt  : trail_evt;
   assign ss_fall    = ~ss_s &  ss_d_reg;
   assign ss_rise    =  ss_s & ~ss_d_reg;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic       bus_access;
   logic       wr_ctrl, wr_stat, wr_data, rd_data;
   logic [7:0] rd_mux;

   assign bus_access = cyc_i & stb_i & ~ack_reg;
   assign wr_ctrl    = bus_access &  we_i & (adr_i == 2'd0);
   assign wr_stat    = bus_access &  we_i & (adr_i == 2'd1);
   assign wr_data    = bus_access &  we_i & (adr_i == 2'd2);
   assign rd_data    = bus_access & ~we_i & (adr_i == 2'd2);

   always_comb begin
      rd_mux = 8'h00;
      case (adr_i)
         2'd0:    rd_mux = {ie_reg, spe_reg, 2'b00, cpol_reg, cpha_reg, 2'b00};
         2'd1:    rd_mux = {rxf_reg, ovr_reg, txe_reg, und_reg, wcol_reg, 2'b00,
                            (state_reg == ST_XFER)};
         2'd2:    rd_mux = rx_hold_reg;
         default: rd_mux = 8'h00;
      endcase
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   logic       load_evt;
   logic       cmpl_evt;
   logic [7:0] rx_byte;

   always_comb begin
      state_next     = state_reg;
      sck_d_next     = sck_s;
      ss_d_next      = ss_s;
      ie_next        = ie_reg;
      spe_next       = spe_reg;
      cpol_next      = cpol_reg;
      cpha_next      = cpha_reg;
      rxf_next       = rxf_reg;
      ovr_next       = ovr_reg;
      txe_next       = txe_reg;
      und_next       = und_reg;
      wcol_next      = wcol_reg;
      rx_hold_next   = rx_hold_reg;
      tx_hold_next   = tx_hold_reg;
      rx_sr_next     = rx_sr_reg;
      tx_sr_next     = tx_sr_reg;
      bcnt_next      = bcnt_reg;
      byte_done_next = byte_done_reg;
      dat_next       = dat_reg;
      ack_next       = bus_access;
      inta_next      = ie_reg & (rxf_reg | ovr_reg | und_reg);
      load_evt       = 1'b0;
      cmpl_evt       = 1'b0;
      rx_byte        = {rx_sr_reg[6:0], mosi_s};

      if (bus_access && !we_i) begin
         dat_next = rd_mux;
      end

      // Frame sequencing. Sample and shift edges are opposite SCK edges,
      // so at most one of them is present in any cycle.
      case (state_reg)
         ST_IDLE: begin
            if (ss_fall && spe_reg) begin
               state_next     = ST_XFER;
               bcnt_next      = 3'd0;
               byte_done_next = 1'b0;
               // CPHA=0 presents the first bit before the first SCK edge.
               load_evt       = ~cpha_reg;
            end
         end
         ST_XFER: begin
            if (ss_rise) begin
               state_next     = ST_IDLE;
               byte_done_next = 1'b0;
            end else if (sample_evt) begin
               rx_sr_next = rx_byte;
               bcnt_next  = bcnt_reg + 3'd1;
               if (bcnt_reg == 3'd7) begin
                  cmpl_evt       = 1'b1;
                  byte_done_next = ~cpha_reg;
               end
            end else if (shift_evt) begin
               // CPHA=1 reloads on the first shift edge of each byte;
               // CPHA=0 reloads on the shift edge that follows a byte.
               if (cpha_reg ? (bcnt_reg == 3'd0) : byte_done_reg) begin
                  load_evt = 1'b1;
               end else begin
                  tx_sr_next = {tx_sr_reg[6:0], 1'b0};
               end
               byte_done_next = 1'b0;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Register updates. Order matters: software clears first, then the
      // hardware events, so a set in the same cycle as a clear wins.
      if (wr_ctrl) begin
         ie_next   = dat_i[7];
         spe_next  = dat_i[6];
         cpol_next = dat_i[3];
         cpha_next = dat_i[2];
      end

      if (wr_stat) begin
         ovr_next  = ovr_reg  & ~dat_i[6];
         und_next  = und_reg  & ~dat_i[4];
         wcol_next = wcol_reg & ~dat_i[3];
      end

      if (rd_data) begin
         rxf_next = 1'b0;
      end

      // The load uses the holding state as it was before any write in
      // this same cycle.
      if (load_evt) begin
         tx_sr_next = txe_reg ? 8'h00 : tx_hold_reg;
         txe_next   = 1'b1;
         if (txe_reg) begin
            und_next = 1'b1;
         end
      end

      // A write that coincides with a load is accepted, since the load has
      // just freed the holding register.
      if (wr_data) begin
         if (txe_reg || load_evt) begin
            tx_hold_next = dat_i;
            txe_next     = 1'b0;
         end else begin
            wcol_next = 1'b1;
         end
      end

      // A DATA read in the same cycle already frees the holding register.
      if (cmpl_evt) begin
         if (rxf_reg && !rd_data) begin
            ovr_next = 1'b1;
         end else begin
            rx_hold_next = rx_byte;
            rxf_next     = 1'b1;
         end
      end

      // Disabled: park the shifter, but leave registers and flags alone.
      if (!spe_reg) begin
         state_next     = ST_IDLE;
         bcnt_next      = 3'd0;
         tx_sr_next     = 8'h00;
         rx_sr_next     = 8'h00;
         byte_done_next = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         sck_d_reg     <= 1'b0;
         ss_d_reg      <= 1'b0;
         ie_reg        <= 1'b0;
         spe_reg       <= 1'b0;
         cpol_reg      <= 1'b0;
         cpha_reg      <= 1'b0;
         rxf_reg       <= 1'b0;
         ovr_reg       <= 1'b0;
         txe_reg       <= 1'b1;
         und_reg       <= 1'b0;
         wcol_reg      <= 1'b0;
         rx_hold_reg   <= 8'h00;
         tx_hold_reg   <= 8'h00;
         rx_sr_reg     <= 8'h00;
         tx_sr_reg     <= 8'h00;
         bcnt_reg      <= 3'd0;
         byte_done_reg <= 1'b0;
         dat_reg       <= 8'h00;
         ack_reg       <= 1'b0;
         inta_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sck_d_reg     <= sck_d_next;
         ss_d_reg      <= ss_d_next;
         ie_reg        <= ie_next;
         spe_reg       <= spe_next;
         cpol_reg      <= cpol_next;
         cpha_reg      <= cpha_next;
         rxf_reg       <= rxf_next;
         ovr_reg       <= ovr_next;
         txe_reg       <= txe_next;
         und_reg       <= und_next;
         wcol_reg      <= wcol_next;
         rx_hold_reg   <= rx_hold_next;
         tx_hold_reg   <= tx_hold_next;
         rx_sr_reg     <= rx_sr_next;
         tx_sr_reg     <= tx_sr_next;
         bcnt_reg      <= bcnt_next;
         byte_done_reg <= byte_done_next;
         dat_reg       <= dat_next;
         ack_reg       <= ack_next;
         inta_reg      <= inta_next;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign dat_o     = dat_reg;
   assign ack_o     = ack_reg;
   assign inta_o    = inta_reg;
   assign miso_o    = tx_sr_reg[7];
   assign miso_oe_o = spe_reg & ~ss_s;

endmodule

// File: tb/tb_simple_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_simple_spi_slave
//
// Drives the SPI pins as a master and the Wishbone port as a CPU. A
// register-level model of the peripheral (flags, holding registers and the
// per-byte load/complete events) predicts what software and the master see.
// -----------------------------------------------------------------------------
module tb_simple_spi_slave;

   localparam int H = 8;   // SCK half period in clk_i cycles

   logic       clk_i = 1'b0;
   logic       rst_i, cyc_i, stb_i, we_i;
   logic [1:0] adr_i;
   logic [7:0] dat_i, dat_o;
   logic       ack_o, inta_o;
   logic       sck_i, ss_n_i, mosi_i, miso_o, miso_oe_o;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic       m_ie, m_cpol, m_cpha;
   logic       m_rxf, m_ovr, m_txe, m_und, m_wcol;
   logic [7:0] m_rx_hold, m_tx_hold;

   always #5 clk_i = ~clk_i;

   simple_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .cyc_i     (cyc_i),
      .stb_i     (stb_i),
      .we_i      (we_i),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .dat_o     (dat_o),
      .ack_o     (ack_o),
      .inta_o    (inta_o),
      .sck_i     (sck_i),
      .ss_n_i    (ss_n_i),
      .mosi_i    (mosi_i),
      .miso_o    (miso_o),
      .miso_oe_o (miso_oe_o)
   );

   // ------------------------------------------------------------ model
   function automatic void model_reset();
      m_ie = 0; m_cpol = 0; m_cpha = 0;
      m_rxf = 0; m_ovr = 0; m_txe = 1; m_und = 0; m_wcol = 0;
      m_rx_hold = 8'h00; m_tx_hold = 8'h00;
   endfunction

   function automatic logic [7:0] model_stat();
      return {m_rxf, m_ovr, m_txe, m_und, m_wcol, 3'b000};
   endfunction

   function automatic logic model_inta();
      return m_ie & (m_rxf | m_ovr | m_und);
   endfunction

   // Byte handed to the shifter: holding register if filled, else zero.
   function automatic logic [7:0] model_load();
      logic [7:0] v;
      if (m_txe) begin
         v = 8'h00;
         m_und = 1'b1;
      end else begin
         v = m_tx_hold;
         m_txe = 1'b1;
      end
      return v;
   endfunction

   function automatic void model_complete(input logic [7:0] b);
      if (m_rxf) m_ovr = 1'b1;
      else begin
         m_rx_hold = b;
         m_rxf = 1'b1;
      end
   endfunction

   // CPHA=0: one load when SS_n falls, then one after every byte.
   // CPHA=1: one load at the start of every byte.
   task automatic model_frame(input int n, input logic [3:0][7:0] mb,
                              output logic [3:0][7:0] exp);
      logic [7:0] ld;
      exp = '0;
      if (!m_cpha) begin
         exp[0] = model_load();
         for (int k = 0; k < n; k++) begin
            model_complete(mb[k]);
            ld = model_load();
            if (k < 3) exp[k+1] = ld;
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            exp[k] = model_load();
            model_complete(mb[k]);
         end
      end
   endtask

   // ------------------------------------------------------------ bus
   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk_i);
      cyc_i = 1; stb_i = 1; we_i = 1; adr_i = a; dat_i = d;
      @(negedge clk_i);
      cyc_i = 0; stb_i = 0; we_i = 0;
      $display("bus wr adr=%0d data=%02h", a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic ack);
      @(negedge clk_i);
      cyc_i = 1; stb_i = 1; we_i = 0; adr_i = a;
      @(negedge clk_i);
      d = dat_o; ack = ack_o;
      cyc_i = 0; stb_i = 0;
      $display("bus rd adr=%0d data=%02h", a, d);
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic ie);
      bus_write(2'd0, {ie, 1'b1, 2'b00, cpol, cpha, 2'b00});
      m_ie = ie; m_cpol = cpol; m_cpha = cpha;
      sck_i = cpol;
      tick(6);
   endtask

   task automatic data_write(input logic [7:0] d);
      bus_write(2'd2, d);
      if (m_txe) begin
         m_tx_hold = d;
         m_txe = 1'b0;
      end else begin
         m_wcol = 1'b1;
      end
   endtask

   task automatic data_read(output logic [7:0] got, output logic [7:0] expv);
      logic a;
      expv = m_rx_hold;
      m_rxf = 1'b0;
      bus_read(2'd2, got, a);
   endtask

   task automatic clear_flags();
      bus_write(2'd1, 8'h58);
      m_ovr = 0; m_und = 0; m_wcol = 0;
   endtask

   // ------------------------------------------------------------ SPI master
   task automatic spi_bits(input logic [7:0] m, input int nbits, output logic [7:0] s);
      s = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         if (!m_cpha) begin
            mosi_i = m[7-i];
            tick(H);
            s[7-i] = miso_o;
            sck_i = ~m_cpol;
            tick(H);
            sck_i = m_cpol;
         end else begin
            sck_i = ~m_cpol;
            mosi_i = m[7-i];
            tick(H);
            s[7-i] = miso_o;
            sck_i = m_cpol;
            tick(H);
         end
      end
   endtask

   task automatic frame_begin();
      ss_n_i = 1'b0;
      tick(H);
   endtask

   task automatic frame_end();
      tick(H);
      ss_n_i = 1'b1;
      tick(H);
   endtask

   task automatic run_frame(input int n, input logic [3:0][7:0] mb, output logic [3:0][7:0] sb);
      logic [7:0] s;
      sb = '0;
      frame_begin();
      for (int k = 0; k < n; k++) begin
         spi_bits(mb[k], 8, s);
         sb[k] = s;
      end
      frame_end();
      $display("spi frame cpol=%0d cpha=%0d bytes=%0d mosi=%h miso=%h",
               m_cpol, m_cpha, n, mb, sb);
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      logic [7:0] v; logic a;
      rst_i = 1; tick(2); rst_i = 0;
      model_reset();
      checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe_o); end
      checks++; if (inta_o !== 1'b0) begin errors++; $display("FAIL reset_inta: got %b expected 0", inta_o); end
      checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
      checks++; if (miso_o !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso_o); end
      checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat_o: got %02h expected 00", dat_o); end
      bus_read(2'd0, v, a);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %02h expected 00", v); end
      checks++; if (a !== 1'b1) begin errors++; $display("FAIL bus_ack: got %b expected 1", a); end
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL reset_stat: got %02h expected %02h", v, model_stat()); end
      bus_write(2'd3, 8'hFF);
      bus_read(2'd3, v, a);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL adr3_read: got %02h expected 00", v); end
   endtask

   task automatic test_mode0();
      logic [7:0] v, e, s; logic a;
      logic [3:0][7:0] mb, exp;
      set_mode(0, 0, 0);
      data_write(8'hA5);
      mb = '0; mb[0] = 8'h3C;
      model_frame(1, mb, exp);
      frame_begin();
      checks++; if (miso_oe_o !== 1'b1) begin errors++; $display("FAIL mode0_miso_oe: got %b expected 1", miso_oe_o); end
      bus_read(2'd1, v, a);
      checks++; if (v[0] !== 1'b1) begin errors++; $display("FAIL mode0_bsy: got %b expected 1", v[0]); end
      spi_bits(mb[0], 8, s);
      frame_end();
      checks++; if (s !== exp[0]) begin errors++; $display("FAIL mode0_master_rx: got %02h expected %02h", s, exp[0]); end
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL mode0_stat: got %02h expected %02h", v, model_stat()); end
      data_read(v, e);
      checks++; if (v !== e) begin errors++; $display("FAIL mode0_data: got %02h expected %02h", v, e); end
      bus_read(2'd1, v, a);
      checks++; if (v[7] !== m_rxf) begin errors++; $display("FAIL mode0_rxf_clear: got %b expected %b", v[7], m_rxf); end
      clear_flags();
   endtask

   task automatic test_modes();
      logic [7:0] v, e; logic a;
      logic [3:0][7:0] mb, exp, sb;
      for (int md = 1; md < 4; md++) begin
         set_mode(md[1], md[0], 0);
         data_write(8'h81);
         mb = '0; mb[0] = 8'h7E;
         model_frame(1, mb, exp);
         run_frame(1, mb, sb);
         checks++; if (sb[0] !== exp[0]) begin errors++; $display("FAIL mode%0d_master_rx: got %02h expected %02h", md, sb[0], exp[0]); end
         data_read(v, e);
         checks++; if (v !== e) begin errors++; $display("FAIL mode%0d_slave_rx: got %02h expected %02h", md, v, e); end
         bus_read(2'd1, v, a);
         checks++; if (v !== model_stat()) begin errors++; $display("FAIL mode%0d_stat: got %02h expected %02h", md, v, model_stat()); end
         clear_flags();
      end
   endtask

   task automatic test_overrun_underrun();
      logic [7:0] v, e; logic a;
      logic [3:0][7:0] mb, exp, sb;
      set_mode(0, 0, 1);
      mb = '0; mb[0] = 8'h11; mb[1] = 8'h22;
      model_frame(2, mb, exp);
      run_frame(2, mb, sb);
      checks++; if (sb[1:0] !== exp[1:0]) begin errors++; $display("FAIL ovr_master_rx: got %h expected %h", sb[1:0], exp[1:0]); end
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL ovr_stat: got %02h expected %02h", v, model_stat()); end
      checks++; if (inta_o !== model_inta()) begin errors++; $display("FAIL ovr_inta: got %b expected %b", inta_o, model_inta()); end
      data_read(v, e);
      checks++; if (v !== e) begin errors++; $display("FAIL ovr_data: got %02h expected %02h", v, e); end
      bus_write(2'd1, 8'h50);
      m_ovr = 0; m_und = 0;
      tick(3);
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL w1c_stat: got %02h expected %02h", v, model_stat()); end
      checks++; if (inta_o !== model_inta()) begin errors++; $display("FAIL w1c_inta: got %b expected %b", inta_o, model_inta()); end
   endtask

   task automatic test_write_collision();
      logic [7:0] v; logic a;
      logic [3:0][7:0] mb, exp, sb;
      set_mode(0, 0, 0);
      data_write(8'h66);
      data_write(8'h55);
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL wcol_stat: got %02h expected %02h", v, model_stat()); end
      mb = '0; mb[0] = 8'h00;
      model_frame(1, mb, exp);
      run_frame(1, mb, sb);
      checks++; if (sb[0] !== exp[0]) begin errors++; $display("FAIL wcol_tx_hold: got %02h expected %02h", sb[0], exp[0]); end
      data_read(v, exp[1]);
      clear_flags();
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL wcol_clear: got %02h expected %02h", v, model_stat()); end
   endtask

   task automatic test_abort();
      logic [7:0] v, e, s, ld; logic a;
      logic [3:0][7:0] mb, exp, sb;
      set_mode(1, 0, 0);
      data_write(8'h3A);
      ld = model_load();
      frame_begin();
      spi_bits(8'hF0, 4, s);
      frame_end();
      checks++; if (s[7:4] !== ld[7:4]) begin errors++; $display("FAIL abort_partial_miso: got %h expected %h", s[7:4], ld[7:4]); end
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL abort_stat: got %02h expected %02h", v, model_stat()); end
      data_write(8'h4B);
      mb = '0; mb[0] = 8'hC5;
      model_frame(1, mb, exp);
      run_frame(1, mb, sb);
      checks++; if (sb[0] !== exp[0]) begin errors++; $display("FAIL abort_next_master: got %02h expected %02h", sb[0], exp[0]); end
      data_read(v, e);
      checks++; if (v !== e) begin errors++; $display("FAIL abort_next_slave: got %02h expected %02h", v, e); end
      clear_flags();
   endtask

   task automatic test_reset_midframe();
      logic [7:0] v, e, s; logic a;
      logic [3:0][7:0] mb, exp, sb;
      set_mode(0, 0, 0);
      data_write(8'h5A);
      frame_begin();
      spi_bits(8'hC3, 3, s);
      rst_i = 1; tick(2); rst_i = 0;
      model_reset();
      bus_write(2'd0, 8'h40);
      spi_bits(8'hC3, 8, s);
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL midrst_miso: got %02h expected 00", s); end
      bus_read(2'd1, v, a);
      checks++; if (v !== model_stat()) begin errors++; $display("FAIL midrst_stat: got %02h expected %02h", v, model_stat()); end
      frame_end();
      data_write(8'h69);
      mb = '0; mb[0] = 8'h96;
      model_frame(1, mb, exp);
      run_frame(1, mb, sb);
      checks++; if (sb[0] !== exp[0]) begin errors++; $display("FAIL midrst_next_master: got %02h expected %02h", sb[0], exp[0]); end
      data_read(v, e);
      checks++; if (v !== e) begin errors++; $display("FAIL midrst_next_slave: got %02h expected %02h", v, e); end
      clear_flags();
   endtask

   task automatic test_random_frames();
      logic [7:0] v, e; logic a;
      logic [3:0][7:0] mb, exp, sb;
      int md, n;
      for (int it = 0; it < 16; it++) begin
         md = $urandom_range(3, 0);
         set_mode(md[1], md[0], 1'($urandom_range(1, 0)));
         if ($urandom_range(3, 0) != 0) data_write(8'($urandom));
         if ($urandom_range(3, 0) == 0) data_write(8'($urandom));
         n = $urandom_range(3, 1);
         mb = '0;
         for (int k = 0; k < n; k++) mb[k] = 8'($urandom);
         model_frame(n, mb, exp);
         run_frame(n, mb, sb);
         for (int k = 0; k < n; k++) begin
            checks++; if (sb[k] !== exp[k]) begin errors++; $display("FAIL rnd%0d_master_byte%0d: got %02h expected %02h", it, k, sb[k], exp[k]); end
         end
         bus_read(2'd1, v, a);
         checks++; if (v !== model_stat()) begin errors++; $display("FAIL rnd%0d_stat: got %02h expected %02h", it, v, model_stat()); end
         checks++; if (inta_o !== model_inta()) begin errors++; $display("FAIL rnd%0d_inta: got %b expected %b", it, inta_o, model_inta()); end
         data_read(v, e);
         checks++; if (v !== e) begin errors++; $display("FAIL rnd%0d_data: got %02h expected %02h", it, v, e); end
         clear_flags();
      end
   endtask

   initial begin
      rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 2'd0; dat_i = 8'h00;
      sck_i = 0; ss_n_i = 1; mosi_i = 0;
      model_reset();
      test_reset();
      test_mode0();
      test_modes();
      test_overrun_underrun();
      test_write_collision();
      test_abort();
      test_reset_midframe();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/simple_spi_slave.md
# simple_spi_slave

SPI slave (target) peripheral: the receiving end of the link driven by the team's `simple_spi` master. It samples an external SCK/SS_n/MOSI against the system clock, shifts bytes in and out in all four SPI modes, and exposes control, status and data registers on an 8-bit Wishbone classic slave port with an interrupt. It sits beside `simple_spi` on the same Wishbone bus.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `sck_i`, `ss_n_i` and `mosi_i`; minimum value is 2.
- `clk_i` in 1: system clock.
- `rst_i` in 1: synchronous reset, active-high.
- `cyc_i` in 1: Wishbone cycle.
- `stb_i` in 1: Wishbone strobe.
- `we_i` in 1: Wishbone write enable.
- `adr_i` in 2: register address.
- `dat_i` in 8: write data.
- `dat_o` out 8: read data, registered.
- `ack_o` out 1: Wishbone acknowledge.
- `inta_o` out 1: interrupt, registered.
- `sck_i` in 1: SPI clock from the master, asynchronous.
- `ss_n_i` in 1: slave select, active-low, asynchronous.
- `mosi_i` in 1: master-out data, asynchronous.
- `miso_o` out 1: slave-out data.
- `miso_oe_o` out 1: MISO output enable.

## Operation
Registers:
- **adr 0 CTRL (R/W):** [7] IE, [6] SPE, [3] CPOL, [2] CPHA; other bits read 0.
- **adr 1 STAT:** [7] RXF (RO), [6] OVR (W1C), [5] TXE (RO), [4] UND (W1C), [3] WCOL (W1C), [0] BSY (RO; 1 while a frame is active).
- **adr 2 DATA:**
  - Read returns the RX holding register and clears RXF.
  - Write with TXE=1 loads the TX holding register and clears TXE.
  - Write with TXE=0 is dropped and sets WCOL.
- **adr 3:** reads 0x00; writes are ignored.

Bus access:
- An access is the cycle where `cyc_i & stb_i & ~ack_o`. Its side effects happen in that cycle.

Front end:
- `sck_i`, `ss_n_i` and `mosi_i` pass through `SYNC_STAGES` flops each.
- A registered copy of synced SCK provides edge detection.
- Leading edge is rise when CPOL=0 and fall when CPOL=1. Trailing edge is the opposite.
- Sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. Shift edge is the other one.

State machine:
- **IDLE → XFER:** on synced SS_n falling while SPE=1. Clear `bcnt`. If CPHA=0, load the shift register (see load rule).
- **XFER, sample edge:** shift synced MOSI into `rx_sr` LSB. Increment `bcnt` (3 bits, wraps 7→0).
- **Byte complete:** the sample edge with `bcnt`=7.
  - If RXF=0, copy `rx_sr` to the RX holding register and set RXF.
  - Otherwise set OVR and keep the old RX holding value.
- **XFER, shift edge:**
  - CPHA=0: `tx_sr` shifts left. If this is the shift edge after a byte completed, load instead.
  - CPHA=1: when `bcnt`=0, load; otherwise shift left.
- **Load rule:** copy the TX holding register to `tx_sr` and set TXE. If TXE was already 1, load 0x00 and set UND.
- **XFER → IDLE:** on synced SS_n rising. Any partial byte is discarded with no flag change.
- Multi-byte frames are supported; each byte is handled independently.

Outputs and enable:
- `miso_o` = `tx_sr`[7].
- `miso_oe_o` = SPE & synced SS_n low.
- SPE=0: force IDLE and clear `bcnt`, `tx_sr` and `rx_sr`. Registers and flags are kept.
- `inta_o` = IE & (RXF | OVR | UND), registered.

## Timing
Reset values:
- CTRL = 0x00.
- STAT = 0x20 (TXE=1).
- RX holding = 0x00; TX holding = 0x00.
- `dat_o` = 0x00; `ack_o` = 0; `inta_o` = 0; `miso_o` = 0; `miso_oe_o` = 0.
- State = IDLE.

Bus timing:
- `ack_o` rises one cycle after the access cycle and stays high for one cycle.
- `dat_o` is valid with `ack_o` and holds the register value sampled in the access cycle.

SPI-side latency:
- From an SCK or SS_n pin edge to the internal edge event: `SYNC_STAGES`+1 clk_i cycles.
- `miso_o` updates one cycle after the event.
- RXF and the RX holding register update one cycle after the completing sample event.
- Supported SCK frequency is at most clk_i/8. Each SCK high and low phase must be at least 4 clk_i cycles.

Simultaneous events:
- **DATA read and byte completion in the same cycle:** the read returns the old value. RXF ends at 1 with the new byte. No OVR.
- **DATA write and load in the same cycle:** the load uses the pre-write holding state. The write is accepted with no WCOL, and TXE ends at 0.
- **W1C and a hardware set of the same flag in the same cycle:** the set wins.
- **Reset mid-frame:** all state returns to the reset values. A frame that resumes without a new SS_n falling edge is ignored until SS_n rises and falls again.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles → CTRL=0x00, STAT=0x20, `miso_oe_o`=0, `inta_o`=0.
- **Mode 0 full-duplex:** CTRL=0x40, write DATA=0xA5; master sends 0x3C → master receives 0xA5; STAT RXF=1 and TXE=1; DATA read returns 0x3C and RXF clears.
- **Modes 1/2/3:** for each, TX 0x81 and master sends 0x7E → both sides receive the exchanged bytes bit-exact.
- **Overrun and underrun:** with TX empty, send two bytes 0x11 then 0x22 without reading → STAT OVR=1, UND=1; DATA reads 0x11; with IE=1, `inta_o`=1; W1C 0x50 clears both flags.
- **Write collision:** with TXE=0, write DATA=0x55 → WCOL=1 and the TX holding register keeps its previous value.
- **Abort:** raise SS_n after 4 bits → RXF unchanged and BSY=0; the next full byte is received correctly.
